// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and decoupled instruction output bundle
interface fetch_queue_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_inst;
  logic        out_ready;
  modport master (
    output imem_addr, imem_rmask, out_valid, out_pc, out_pc_next, out_inst,
    input  imem_rdata, imem_resp, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, imem_rmask, out_valid, out_pc, out_pc_next, out_inst,
    output imem_rdata, imem_resp, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding imem fetcher feeding a DEPTH-entry {pc, inst} FIFO with redirect flush
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'haaaa_a000
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, PEND, DROP} state_t;
  state_t        state;
  logic [31:0]   fetch_pc, saved_pc;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic          enq, deq;
  logic [CW-1:0] cnt_next;
  assign deq      = (count != '0) & bus.out_ready & ~bus.redirect;
  assign enq      = (state == PEND) & bus.imem_resp & ~bus.redirect;
  assign cnt_next = bus.redirect ? '0 : count + CW'(enq) - CW'(deq);
  assign bus.imem_addr   = fetch_pc;
  assign bus.imem_rmask  = (state == IDLE) ? 4'h0 : 4'hF;
  assign bus.out_valid   = count != '0;
  assign bus.out_pc      = pc_mem[head];
  assign bus.out_pc_next = pc_mem[head] + 32'd4;
  assign bus.out_inst    = inst_mem[head];
  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]   <= fetch_pc;
      inst_mem[tail] <= bus.imem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      saved_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      count <= cnt_next;
      if (bus.redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
      end
      case (state)
        IDLE: begin
          if (bus.redirect) fetch_pc <= bus.redirect_pc;
          if (bus.redirect || cnt_next < FULL) state <= PEND;
        end
        PEND: begin
          if (bus.imem_resp) begin
            fetch_pc <= bus.redirect ? bus.redirect_pc : fetch_pc + 32'd4;
            state    <= (bus.redirect || cnt_next < FULL) ? PEND : IDLE;
          end else if (bus.redirect) begin
            saved_pc <= bus.redirect_pc;
            state    <= DROP;
          end
        end
        DROP: begin
          // The outstanding request must complete before the new target can be driven.
          if (bus.imem_resp) begin
            fetch_pc <= bus.redirect ? bus.redirect_pc : saved_pc;
            state    <= PEND;
          end else if (bus.redirect) saved_pc <= bus.redirect_pc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
